seq_scan_ctrl: RTL and testbench

- Controller that streams parallel words through an overlapping serial pattern detector, one bit per clock, MSB first.
- Sequences the detector datapath: accepts a word over a valid/ready handshake, shifts its bits into the detector, and counts pattern hits.
- Returns a per-word result over a second valid/ready handshake.
- Sits between a word-oriented producer/consumer and the bit-serial detection logic of the FSM library.

---
 rtl/seq_scan_ctrl.sv | 134 +++++++++++++
 tb/tb_seq_scan_ctrl.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/seq_scan_ctrl.sv
// Word-to-bit sequencer around an overlapping serial pattern detector.
// Accepts a word, shifts it MSB-first through the detector, returns the hit count.
module seq_scan_ctrl #(
  parameter int unsigned      WORD_W = 8,
  parameter int unsigned      PAT_W  = 4,
  parameter logic [PAT_W-1:0] PAT    = 4'b1101,
  parameter int unsigned      CNT_W  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] in_word,
  input  logic              keep_hist,
  input  logic              abort,
  output logic              hit,
  output logic              busy,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CNT_W-1:0]  match_cnt
);

  localparam int unsigned BIT_W   = $clog2(WORD_W + 1);
  localparam int unsigned FILL_W  = $clog2(PAT_W + 1);
  localparam int unsigned FILL_W1 = FILL_W + 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [WORD_W-1:0] shreg_q, shreg_d;
  logic [PAT_W-1:0]  hist_q, hist_d;
  logic [FILL_W-1:0] fill_q, fill_d;
  logic [BIT_W-1:0]  bitcnt_q, bitcnt_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  match_cnt_d;
  logic              hit_d, busy_d, out_valid_d, in_ready_d;

  logic              bit_c;
  logic [PAT_W-1:0]  nh_c;
  logic              fill_ok_c;
  logic              match_c;

  // Detector view of the bit currently leaving the shift register
  always_comb begin
    bit_c     = shreg_q[WORD_W-1];
    nh_c      = {hist_q[PAT_W-2:0], bit_c};
    fill_ok_c = (FILL_W1'(fill_q) + FILL_W1'(1)) >= FILL_W1'(PAT_W);
    match_c   = (nh_c == PAT) && fill_ok_c;
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d     = state_q;
    shreg_d     = shreg_q;
    hist_d      = hist_q;
    fill_d      = fill_q;
    bitcnt_d    = bitcnt_q;
    cnt_d       = cnt_q;
    match_cnt_d = match_cnt;
    hit_d       = 1'b0;

    if (abort) begin
      state_d = S_IDLE;
      hist_d  = '0;
      fill_d  = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid && in_ready) begin
            state_d  = S_SHIFT;
            shreg_d  = in_word;
            bitcnt_d = BIT_W'(WORD_W);
            cnt_d    = '0;
            if (!keep_hist) begin
              hist_d = '0;
              fill_d = '0;
            end
          end
        end
        S_SHIFT: begin
          shreg_d  = shreg_q << 1;
          hist_d   = nh_c;
          fill_d   = (fill_q == FILL_W'(PAT_W)) ? fill_q : fill_q + FILL_W'(1);
          cnt_d    = cnt_q + CNT_W'(match_c);
          hit_d    = match_c;
          bitcnt_d = bitcnt_q - BIT_W'(1);
          if (bitcnt_q == BIT_W'(1)) begin
            state_d     = S_DONE;
            match_cnt_d = cnt_q + CNT_W'(match_c);
          end
        end
        S_DONE: begin
          if (out_ready) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end

    in_ready_d  = (state_d == S_IDLE);
    busy_d      = (state_d == S_SHIFT);
    out_valid_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      shreg_q   <= '0;
      hist_q    <= '0;
      fill_q    <= '0;
      bitcnt_q  <= '0;
      cnt_q     <= '0;
      match_cnt <= '0;
      hit       <= 1'b0;
      busy      <= 1'b0;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      hist_q    <= hist_d;
      fill_q    <= fill_d;
      bitcnt_q  <= bitcnt_d;
      cnt_q     <= cnt_d;
      match_cnt <= match_cnt_d;
      hit       <= hit_d;
      busy      <= busy_d;
      out_valid <= out_valid_d;
      in_ready  <= in_ready_d;
    end
  end

endmodule

// File: tb/tb_seq_scan_ctrl.sv
// Self-checking bench for seq_scan_ctrl: directed table, corner sequences, random words.
module tb_seq_scan_ctrl;

  localparam int unsigned WORD_W = 8;
  localparam int unsigned PAT_W  = 4;
  localparam int unsigned CNT_W  = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid, in_ready;
  logic [WORD_W-1:0] in_word;
  logic              keep_hist, abort;
  logic              hit, busy, out_valid, out_ready;
  logic [CNT_W-1:0]  match_cnt;

  seq_scan_ctrl #(.WORD_W(WORD_W), .PAT_W(PAT_W), .PAT(4'b1101), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_word(in_word),
    .keep_hist(keep_hist), .abort(abort), .hit(hit), .busy(busy), .out_valid(out_valid),
    .out_ready(out_ready), .match_cnt(match_cnt)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference: plain bit history since last clear, and last reported count
  logic hq[$];
  int   last_cnt = 0;
  logic [PAT_W-1:0] pat_ref = 4'b1101;

  typedef struct {
    logic [WORD_W-1:0] word;
    logic              keep;
    int                hold;
    int                exp_cnt;
  } vec_t;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic model_push(input logic b);
    logic [PAT_W-1:0] v;
    hq.push_back(b);
    if (hq.size() > PAT_W) void'(hq.pop_front());
    if (hq.size() < PAT_W) return 1'b0;
    v = '0;
    for (int i = 0; i < PAT_W; i++) v = {v[PAT_W-2:0], hq[i]};
    return (v == pat_ref);
  endfunction

  // Present one word, follow it bit by bit, optionally hold DONE or abort mid-shift
  task automatic run_word(input logic [WORD_W-1:0] w, input logic kh, input int hold,
                          input int abort_at, input bit use_exp, input int exp_cnt);
    int   mcount;
    logic m;
    in_word = w; keep_hist = kh; in_valid = 1'b1; out_ready = 1'b1; abort = 1'b0;
    check("in_ready_idle", int'(in_ready), 1);
    @(posedge clk); #1;
    if (!kh) hq.delete();
    in_valid  = 1'($urandom_range(0, 1));
    in_word   = WORD_W'($urandom);
    keep_hist = 1'($urandom_range(0, 1));
    check("busy_shift", int'(busy), 1);
    check("in_ready_shift", int'(in_ready), 0);
    mcount = 0;
    for (int k = 1; k <= WORD_W; k++) begin
      if (k == abort_at) abort = 1'b1;
      @(posedge clk); #1;
      if (k == abort_at) begin
        abort = 1'b0; in_valid = 1'b0;
        hq.delete();
        check("abort_in_ready", int'(in_ready), 1);
        check("abort_busy", int'(busy), 0);
        check("abort_hit", int'(hit), 0);
        check("abort_out_valid", int'(out_valid), 0);
        check("abort_match_cnt", int'(match_cnt), last_cnt);
        return;
      end
      m = model_push(w[WORD_W-k]);
      mcount += int'(m);
      check("hit_bit", int'(hit), int'(m));
      if (k < WORD_W) check("out_valid_early", int'(out_valid), 0);
    end
    last_cnt = mcount;
    check("out_valid_done", int'(out_valid), 1);
    check("busy_done", int'(busy), 0);
    check("in_ready_done", int'(in_ready), 0);
    check("match_cnt_model", int'(match_cnt), mcount);
    if (use_exp) check("match_cnt_table", int'(match_cnt), exp_cnt);
    if (hold > 0) begin
      out_ready = 1'b0; in_valid = 1'b1; in_word = WORD_W'($urandom);
      repeat (hold) begin
        @(posedge clk); #1;
        check("hold_out_valid", int'(out_valid), 1);
        check("hold_match_cnt", int'(match_cnt), mcount);
        check("hold_in_ready", int'(in_ready), 0);
        check("hold_hit", int'(hit), 0);
      end
    end
    out_ready = 1'b1; in_valid = 1'b0;
    @(posedge clk); #1;
    check("release_out_valid", int'(out_valid), 0);
    check("release_in_ready", int'(in_ready), 1);
    check("release_hit", int'(hit), 0);
    check("release_match_cnt", int'(match_cnt), last_cnt);
  endtask

  vec_t vecs[8];

  initial begin
    vecs[0] = '{8'b1101_1010, 1'b0, 0, 2};
    vecs[1] = '{8'hFF,        1'b0, 0, 0};
    vecs[2] = '{8'h00,        1'b0, 0, 0};
    vecs[3] = '{8'b0000_0110, 1'b0, 0, 0};
    vecs[4] = '{8'b1000_0000, 1'b1, 0, 1};
    vecs[5] = '{8'b0000_0110, 1'b0, 0, 0};
    vecs[6] = '{8'b1000_0000, 1'b0, 0, 0};
    vecs[7] = '{8'b1101_1010, 1'b0, 5, 2};

    rst_n = 1'b0; in_valid = 1'b0; in_word = '0; keep_hist = 1'b0;
    abort = 1'b0; out_ready = 1'b1;
    #12;
    check("rst_in_ready", int'(in_ready), 1);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_hit", int'(hit), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_match_cnt", int'(match_cnt), 0);
    #10 rst_n = 1'b1;
    @(posedge clk); #1;

    foreach (vecs[i]) run_word(vecs[i].word, vecs[i].keep, vecs[i].hold, 0, 1'b1, vecs[i].exp_cnt);

    // Abort on the 4th shift cycle, exactly where the first match would land
    run_word(8'b1101_1101, 1'b0, 0, 4, 1'b0, 0);
    check("after_abort_cnt", int'(match_cnt), 2);
    run_word(8'b1101_0000, 1'b1, 0, 0, 1'b1, 1);

    // Handshake coinciding with abort in IDLE is ignored
    in_valid = 1'b1; in_word = 8'b1101_1101; abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0; in_valid = 1'b0;
    hq.delete();
    check("abort_idle_busy", int'(busy), 0);
    check("abort_idle_in_ready", int'(in_ready), 1);

    // Asynchronous reset mid-shift
    in_valid = 1'b1; in_word = 8'b1101_1010; keep_hist = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("arst_in_ready", int'(in_ready), 1);
    check("arst_busy", int'(busy), 0);
    check("arst_out_valid", int'(out_valid), 0);
    check("arst_hit", int'(hit), 0);
    check("arst_match_cnt", int'(match_cnt), 0);
    #2 rst_n = 1'b1;
    hq.delete();
    last_cnt = 0;
    @(posedge clk); #1;
    run_word(8'b1010_0000, 1'b1, 0, 0, 1'b1, 0);

    // Random words with random history, backpressure and occasional abort
    for (int n = 0; n < 60; n++) begin
      logic [WORD_W-1:0] w;
      int ab;
      w  = WORD_W'($urandom);
      ab = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, WORD_W)) : 0;
      run_word(w, 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)), ab, 1'b0, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
